data_mem_ctrl: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle MEM-stage data memory. Sits between EX/MEM and MEM/WB pipeline registers.
- Accepts one load or store per request with a valid/ready handshake. Models a configurable access latency and supports byte/half/word/double transfers.
- Keeps the STUR write-data forwarding mux from WB. Adds alignment/range error reporting and a `busy` stall output for the hazard unit.

---
 rtl/data_mem_ctrl.sv | 135 +++++++++++++
 tb/tb_data_mem_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Multi-cycle MEM-stage data memory: valid/ready request, fixed access latency,
// byte/half/word/double little-endian transfers with alignment and range checking.
module data_mem_ctrl #(
    parameter int DATA_W      = 64,
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic [3:0]        xfer_size,
    input  logic [63:0]       address,
    input  logic [DATA_W-1:0] db_mem,
    input  logic [DATA_W-1:0] alu_result_wb,
    input  logic              forward_stur,
    output logic              resp_valid,
    output logic [DATA_W-1:0] read_data,
    output logic              err,
    output logic              busy
);
    localparam int NB = DATA_W / 8;
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_r;
    logic [63:0]       addr_r;
    logic [3:0]        size_r;
    logic              rd_r;
    logic              wr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [CW-1:0]     cnt_r;

    logic [7:0]        mem [DEPTH_BYTES];

    logic              accept_s;
    logic              size_ok_s;
    logic              too_wide_s;
    logic              misalign_s;
    logic              range_s;
    logic              err_s;
    logic              we_s;
    logic [DATA_W-1:0] rdata_s;

    // Requests with neither read nor write set are never accepted.
    assign accept_s   = req_valid && req_ready && (mem_read || mem_write);
    assign size_ok_s  = (size_r == 4'd1) || (size_r == 4'd2) || (size_r == 4'd4) || (size_r == 4'd8);
    assign too_wide_s = ({28'd0, size_r} * 32'd8) > 32'(DATA_W);
    assign misalign_s = (addr_r & ({60'd0, size_r} - 64'd1)) != 64'd0;
    // Full 65-bit sum so large addresses cannot wrap back into range.
    assign range_s    = ({1'b0, addr_r} + {61'd0, size_r}) > 65'(DEPTH_BYTES);
    assign err_s      = (rd_r && wr_r) || !size_ok_s || too_wide_s || misalign_s || range_s;
    assign we_s       = (state_r == ACCESS) && (cnt_r == CW'(0)) && wr_r && !err_s;

    // Gather the addressed bytes, zero-extending beyond the transfer size.
    always_comb begin
        rdata_s = '0;
        for (int i = 0; i < NB; i++) begin
            if (4'(i) < size_r) begin
                rdata_s[8*i +: 8] = mem[addr_r[AW-1:0] + AW'(i)];
            end else begin
                rdata_s[8*i +: 8] = 8'h00;
            end
        end
    end

    // Byte-lane store into the array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            for (int i = 0; i < NB; i++) begin
                if (4'(i) < size_r) begin
                    mem[addr_r[AW-1:0] + AW'(i)] <= wdata_r[8*i +: 8];
                end
            end
        end
    end

    // Request FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            read_data  <= '0;
            addr_r     <= 64'd0;
            size_r     <= 4'd0;
            rd_r       <= 1'b0;
            wr_r       <= 1'b0;
            wdata_r    <= '0;
            cnt_r      <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state_r)
                IDLE, RESP: begin
                    if (accept_s) begin
                        addr_r    <= address;
                        size_r    <= xfer_size;
                        rd_r      <= mem_read;
                        wr_r      <= mem_write;
                        wdata_r   <= forward_stur ? alu_result_wb : db_mem;
                        cnt_r     <= CW'(LATENCY - 1);
                        state_r   <= ACCESS;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                ACCESS: begin
                    if (cnt_r != CW'(0)) begin
                        cnt_r <= cnt_r - CW'(1);
                    end else begin
                        state_r    <= RESP;
                        resp_valid <= 1'b1;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                        err        <= err_s;
                        read_data  <= (rd_r && !err_s) ? rdata_s : '0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: directed scenarios plus random traffic
// checked against a byte-array reference model.
module tb_data_mem_ctrl;
    localparam int DW    = 64;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [3:0]  xfer_size = 4'd0;
    logic [63:0] address = 64'd0;
    logic [63:0] db_mem = 64'd0;
    logic [63:0] alu_result_wb = 64'd0;
    logic        forward_stur = 1'b0;
    logic        resp_valid;
    logic [63:0] read_data;
    logic        err;
    logic        busy;

    data_mem_ctrl #(.DATA_W(DW), .DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .mem_write(mem_write), .mem_read(mem_read), .xfer_size(xfer_size),
        .address(address), .db_mem(db_mem), .alu_result_wb(alu_result_wb),
        .forward_stur(forward_stur), .resp_valid(resp_valid), .read_data(read_data),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [63:0] data;
        int          acc;
    } exp_t;

    exp_t        sbq[$];
    int          resp_log[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 1'b1;
    byte unsigned bm[DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic bit m_err(input bit rd, input bit wr, input int s, input logic [63:0] a);
        if (rd && wr) return 1'b1;
        if (!(s == 1 || s == 2 || s == 4 || s == 8)) return 1'b1;
        if (s * 8 > DW) return 1'b1;
        if (a % 64'(s) != 64'd0) return 1'b1;
        if (a >= 64'(DEPTH) || a + 64'(s) > 64'(DEPTH)) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: stall/ready expectations every cycle, scoreboard pop on each response.
    always @(negedge clk) begin
        bit   bexp;
        exp_t e;
        if (mon_en) begin
            bexp = (sbq.size() > 0) && (cyc >= sbq[0].acc) && (cyc < sbq[0].acc + LAT);
            check64("busy", {63'd0, busy}, {63'd0, bexp});
            check64("req_ready", {63'd0, req_ready}, {63'd0, !bexp});
        end
        if (resp_valid) begin
            resp_log.push_back(cyc);
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected no response (cycle %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                check64("latency", 64'(cyc), 64'(e.acc + LAT));
                check64("err", {63'd0, err}, {63'd0, e.err});
                check64("read_data", read_data, e.data);
            end
        end
    end

    // Drive one request starting at a negedge; returns at the negedge after acceptance.
    task automatic issue(input bit rd, input bit wr, input int sz, input logic [63:0] a,
                         input logic [63:0] dbm, input logic [63:0] alu, input bit fwd);
        exp_t        e;
        logic [63:0] wd;
        int          n;
        mem_read = rd; mem_write = wr; xfer_size = 4'(sz); address = a;
        db_mem = dbm; alu_result_wb = alu; forward_stur = fwd; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 within 20 cycles");
            req_valid = 1'b0;
            return;
        end
        e.acc  = cyc + 1;
        e.err  = m_err(rd, wr, sz, a);
        e.data = 64'd0;
        wd     = fwd ? alu : dbm;
        if (!e.err) begin
            for (int i = 0; i < sz; i++) begin
                if (wr) bm[int'(a) + i] = wd[8*i +: 8];
                else    e.data = e.data | (64'(bm[int'(a) + i]) << (8 * i));
            end
        end
        sbq.push_back(e);
        @(negedge clk);
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check64({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
        check64({tag, "_resp_valid"}, {63'd0, resp_valid}, 64'd0);
        check64({tag, "_err"}, {63'd0, err}, 64'd0);
        check64({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check64({tag, "_read_data"}, read_data, 64'd0);
    endtask

    initial begin
        int          n0;
        int          sz;
        int          r;
        int          sz_tab[8];
        bit          rd;
        bit          wr;
        logic [63:0] a;
        sz_tab = '{1, 2, 4, 8, 8, 3, 0, 12};

        #1 reset_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Define every byte so later loads have known expectations.
        for (int i = 0; i < DEPTH / 8; i++)
            issue(0, 1, 8, 64'(i * 8), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));

        issue(0, 1, 8, 64'd16, 64'h0123456789ABCDEF, 64'h1111, 0);
        issue(1, 0, 8, 64'd16, 64'd0, 64'd0, 0);

        issue(0, 1, 8, 64'd24, 64'h45, 64'hDEAD, 1);
        issue(1, 0, 8, 64'd24, 64'd0, 64'd0, 0);
        issue(0, 1, 8, 64'd24, 64'h45, 64'hDEAD, 0);
        issue(1, 0, 8, 64'd24, 64'd0, 64'd0, 0);

        issue(0, 1, 1, 64'd16, 64'hAA, 64'd0, 0);
        issue(1, 0, 8, 64'd16, 64'd0, 64'd0, 0);
        issue(1, 0, 2, 64'd22, 64'd0, 64'd0, 0);

        issue(1, 0, 4, 64'd18, 64'd0, 64'd0, 0);
        issue(0, 1, 8, 64'd1020, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
        issue(1, 0, 8, 64'd1016, 64'd0, 64'd0, 0);
        issue(1, 0, 3, 64'd16, 64'd0, 64'd0, 0);
        issue(1, 1, 8, 64'd16, 64'h5, 64'd0, 0);
        drain();

        // A request with no operation must be ignored.
        req_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check64("ignored_ready", {63'd0, req_ready}, 64'd1);
        end
        req_valid = 1'b0;

        n0 = resp_log.size();
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) issue(0, 1, 8, 64'd32, {$urandom, $urandom}, 64'd0, 0);
            else            issue(1, 0, 8, 64'd32, 64'd0, 64'd0, 0);
        end
        drain();
        if (resp_log.size() >= n0 + 4) begin
            for (int k = 1; k < 4; k++)
                check64("b2b_gap", 64'(resp_log[n0 + k] - resp_log[n0 + k - 1]), 64'(LAT + 1));
        end else begin
            checks++;
            errors++;
            $display("FAIL b2b_count: got %0d responses expected 4", resp_log.size() - n0);
        end

        issue(0, 1, 1, 64'd40, 64'hFF, 64'd0, 0);
        drain();
        mon_en = 1'b0;
        mem_write = 1'b1; xfer_size = 4'd1; address = 64'd40; db_mem = 64'h11;
        forward_stur = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0; mem_write = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        issue(1, 0, 1, 64'd40, 64'd0, 64'd0, 0);
        issue(1, 0, 8, 64'd40, 64'd0, 64'd0, 0);
        drain();

        for (int k = 0; k < 80; k++) begin
            r  = $urandom_range(0, 9);
            rd = (r >= 5);
            wr = (r <= 4) || (r == 9);
            sz = sz_tab[$urandom_range(0, 7)];
            a  = 64'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 3) != 0 && sz > 0) a = a & ~64'(sz - 1);
            if ($urandom_range(0, 15) == 0) a = {$urandom, $urandom};
            issue(rd, wr, sz, a, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
